vga_timing_gen: RTL

Parametrised VGA/VESA timing generator, successor to the fixed 640x480 scan counter. Produces registered hsync/vsync/de, pixel coordinates and line/frame strobes from a system clock via an internal pixel-clock-enable divider. Sits between the system clock domain and the pixel renderer and framebuffer reader. Runtime enable restarts the frame cleanly.

---
 rtl/vga_timing_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA timing generator: pixel-clock-enable divider, h/v scan counters,
// registered sync/de/coordinates and line/frame strobes. Define VGA_TIMING_PREFETCH_EN for nx/ny/nde lookahead.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [CNT_W-1:0] nx,
  output logic [CNT_W-1:0] ny,
  output logic             nde
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam bit CNT_OK = (((H_TOTAL - 1) >> CNT_W) == 0) && (((V_TOTAL - 1) >> CNT_W) == 0);

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             tick;
  logic             de_now;
  logic             hs_act;
  logic             vs_act;

  function automatic logic in_active(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  assign tick = en && (div == DIV_LAST);

  // Next scan position, used both for the counter update and the lookahead outputs.
  always_comb begin
    h_next = h_cnt + CNT_W'(1);
    v_next = v_cnt;
    if (h_cnt == H_LAST) begin
      h_next = '0;
      v_next = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    de_now = in_active(h_cnt, v_cnt);
    hs_act = (h_cnt >= H_SS) && (h_cnt < H_SE);
    vs_act = (v_cnt >= V_SS) && (v_cnt < V_SE);
  end

  // Divider, counters and pin registers; en=0 parks everything at the reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_ce      <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_ce      <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + DIV_W'(1);
      pix_ce      <= tick;
      line_start  <= tick && (h_cnt == '0);
      frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      if (tick) begin
        h_cnt <= h_next;
        v_cnt <= v_next;
        hsync <= HS_POL ? hs_act : ~hs_act;
        vsync <= VS_POL ? vs_act : ~vs_act;
        de    <= de_now;
        x     <= de_now ? h_cnt : '0;
        y     <= de_now ? v_cnt : '0;
      end
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  logic de_nxt;
  assign de_nxt = in_active(h_next, v_next);

  // Lookahead: what x/y/de will show at the following pix_ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nx  <= '0;
      ny  <= '0;
      nde <= 1'b0;
    end else if (!en) begin
      nx  <= '0;
      ny  <= '0;
      nde <= 1'b0;
    end else if (tick) begin
      nx  <= de_nxt ? h_next : '0;
      ny  <= de_nxt ? v_next : '0;
      nde <= de_nxt;
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (CNT_OK) else $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
`endif

endmodule
